// File: rtl/cv32e41s_tcm_pkg.sv
// Shared types for the TCM DMA initiator: modes, completion status, FSM states
// and the command range check.
package cv32e41s_tcm_pkg;

  localparam int unsigned TCM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    MODE_COPY  = 2'd0,
    MODE_FILL  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_RSVD  = 2'd3
  } dma_mode_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_CMD_ERR = 2'd1,
    STAT_ABORTED = 2'd2,
    STAT_BUS_ERR = 2'd3
  } dma_status_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RWAIT = 3'd2,
    S_WR    = 3'd3,
    S_WWAIT = 3'd4,
    S_FIN   = 3'd5
  } dma_state_e;

  // True when a byte address is misaligned or the word range runs past the TCM.
  function automatic logic range_bad(input logic [31:0] addr,
                                     input logic [31:0] len,
                                     input logic [31:0] mem_size);
    logic [33:0] end_w;
    end_w = 34'(addr[31:2]) + 34'(len);
    return (addr[1:0] != 2'b00) || (end_w > 34'(mem_size));
  endfunction

endpackage

// File: rtl/cv32e41s_tcm_dma_addr_gen.sv
// Source/destination address and remaining-word bookkeeping for the TCM DMA.
module cv32e41s_tcm_dma_addr_gen
  import cv32e41s_tcm_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [31:0]      src_o,
  output logic [31:0]      src_nxt_o,
  output logic [31:0]      dst_nxt_o,
  output logic             last_o
);

  logic [31:0]      src_d, src_q;
  logic [31:0]      dst_d, dst_q;
  logic [LEN_W-1:0] rem_d, rem_q;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      rem_d = len_i;
    end else if (adv_i) begin
      src_d = src_q + 32'(TCM_WORD_BYTES);
      dst_d = dst_q + 32'(TCM_WORD_BYTES);
      rem_d = rem_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
    end
  end

  // Next-cycle addresses let the top register its bus outputs without a bubble.
  assign src_o     = src_q;
  assign src_nxt_o = src_d;
  assign dst_nxt_o = dst_d;
  assign last_o    = (rem_q == LEN_W'(1));

endmodule

// File: rtl/cv32e41s_tcm_dma.sv
// TCM b-port DMA initiator: word COPY / FILL / CHECK with abort and bus timeout,
// relying on the TCM's fixed one-cycle response.
module cv32e41s_tcm_dma
  import cv32e41s_tcm_pkg::*;
#(
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned MEM_SIZE = 1024,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_mode_i,
  input  logic [31:0]      cmd_src_i,
  input  logic [31:0]      cmd_dst_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [31:0]      cmd_pattern_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [LEN_W-1:0] mism_cnt_o,
  output logic [31:0]      first_mism_addr_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  dma_state_e       state_d, state_q;
  dma_mode_e        mode_d, mode_q;
  dma_status_e      status_d, status_q;
  logic [31:0]      pat_d, pat_q;
  logic [TMO_W-1:0] tmo_d, tmo_q;
  logic             abort_d, abort_q;
  logic [LEN_W-1:0] mism_d, mism_q;
  logic [31:0]      first_d, first_q;

  logic             cmd_ready_d, cmd_ready_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             mem_req_d, mem_req_q;
  logic             mem_we_d, mem_we_q;
  logic [3:0]       mem_be_d, mem_be_q;
  logic [31:0]      mem_addr_d, mem_addr_q;
  logic [31:0]      mem_wdata_d, mem_wdata_q;

  logic             load, adv, word_done, cmd_err;
  logic [31:0]      src_cur, src_nxt, dst_nxt;
  logic             last_word;

  cv32e41s_tcm_dma_addr_gen #(.LEN_W(LEN_W)) u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .adv_i     (adv),
    .src_i     (cmd_src_i),
    .dst_i     (cmd_dst_i),
    .len_i     (cmd_len_i),
    .src_o     (src_cur),
    .src_nxt_o (src_nxt),
    .dst_nxt_o (dst_nxt),
    .last_o    (last_word)
  );

  // Only the addresses a mode actually uses are range-checked.
  always_comb begin
    cmd_err = 1'b0;
    unique case (dma_mode_e'(cmd_mode_i))
      MODE_COPY:  cmd_err = range_bad(cmd_src_i, 32'(cmd_len_i), 32'(MEM_SIZE)) ||
                            range_bad(cmd_dst_i, 32'(cmd_len_i), 32'(MEM_SIZE));
      MODE_FILL:  cmd_err = range_bad(cmd_dst_i, 32'(cmd_len_i), 32'(MEM_SIZE));
      MODE_CHECK: cmd_err = range_bad(cmd_src_i, 32'(cmd_len_i), 32'(MEM_SIZE));
      default:    cmd_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    status_d  = status_q;
    pat_d     = pat_q;
    tmo_d     = tmo_q;
    abort_d   = abort_q | (abort_i && (state_q != S_IDLE));
    mism_d    = mism_q;
    first_d   = first_q;
    load      = 1'b0;
    adv       = 1'b0;
    word_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          load     = 1'b1;
          mode_d   = dma_mode_e'(cmd_mode_i);
          pat_d    = cmd_pattern_i;
          status_d = STAT_OK;
          mism_d   = '0;
          first_d  = '0;
          abort_d  = 1'b0;
          tmo_d    = '0;
          if (cmd_err) begin
            state_d  = S_FIN;
            status_d = STAT_CMD_ERR;
          end else if (cmd_len_i == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = (dma_mode_e'(cmd_mode_i) == MODE_FILL) ? S_WR : S_RD;
          end
        end
      end
      S_RD: begin
        state_d = S_RWAIT;
        tmo_d   = '0;
      end
      S_WR: begin
        state_d = S_WWAIT;
        tmo_d   = '0;
      end
      S_RWAIT, S_WWAIT: begin
        if (mem_rvalid_i) begin
          if (state_q == S_RWAIT && mode_q == MODE_COPY) begin
            state_d = S_WR;
          end else begin
            word_done = 1'b1;
          end
          if (state_q == S_RWAIT && mode_q == MODE_CHECK && mem_rdata_i != pat_q) begin
            if (mism_q != {LEN_W{1'b1}}) mism_d = mism_q + LEN_W'(1);
            if (mism_q == '0) first_d = src_cur;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d  = S_FIN;
          status_d = STAT_BUS_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort is honoured only at a word boundary; the last word always ends OK.
    if (word_done) begin
      adv = 1'b1;
      if (last_word) begin
        state_d = S_FIN;
      end else if (abort_q || abort_i) begin
        state_d  = S_FIN;
        status_d = STAT_ABORTED;
      end else begin
        state_d = (mode_q == MODE_FILL) ? S_WR : S_RD;
      end
    end

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
    mem_req_d   = (state_d == S_RD) || (state_d == S_WR);
    mem_we_d    = (state_d == S_WR);
    mem_be_d    = mem_req_d ? 4'hF : 4'h0;
    mem_addr_d  = (state_d == S_RD) ? src_nxt :
                  (state_d == S_WR) ? dst_nxt : 32'h0;
    mem_wdata_d = (state_d != S_WR)  ? 32'h0 :
                  (mode_d == MODE_FILL) ? pat_d : mem_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_COPY;
      status_q    <= STAT_OK;
      pat_q       <= '0;
      tmo_q       <= '0;
      abort_q     <= 1'b0;
      mism_q      <= '0;
      first_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      status_q    <= status_d;
      pat_q       <= pat_d;
      tmo_q       <= tmo_d;
      abort_q     <= abort_d;
      mism_q      <= mism_d;
      first_q     <= first_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cmd_ready_o       = cmd_ready_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign status_o          = status_q;
  assign mism_cnt_o        = mism_q;
  assign first_mism_addr_o = first_q;
  assign mem_req_o         = mem_req_q;
  assign mem_we_o          = mem_we_q;
  assign mem_be_o          = mem_be_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_wdata_o       = mem_wdata_q;

endmodule

// File: tb/tb_cv32e41s_tcm_dma.sv
// Directed bench for cv32e41s_tcm_dma with a one-cycle TCM responder model.
module tb_cv32e41s_tcm_dma;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_mode_i = 2'd0;
  logic [31:0] cmd_src_i = 32'h0;
  logic [31:0] cmd_dst_i = 32'h0;
  logic [15:0] cmd_len_i = 16'h0;
  logic [31:0] cmd_pattern_i = 32'h0;
  logic        abort_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  status_o;
  logic [15:0] mism_cnt_o;
  logic [31:0] first_mism_addr_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:1023];
  logic        resp_en = 1'b1;
  int          abort_at = -1;
  int          nreq, nwr;
  logic [15:0] we_pat;
  int          req_cyc [0:7];
  int          dc;

  cv32e41s_tcm_dma #(.LEN_W(16), .MEM_SIZE(1024), .TIMEOUT(15)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .cmd_valid_i       (cmd_valid_i),
    .cmd_ready_o       (cmd_ready_o),
    .cmd_mode_i        (cmd_mode_i),
    .cmd_src_i         (cmd_src_i),
    .cmd_dst_i         (cmd_dst_i),
    .cmd_len_i         (cmd_len_i),
    .cmd_pattern_i     (cmd_pattern_i),
    .abort_i           (abort_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .status_o          (status_o),
    .mism_cnt_o        (mism_cnt_o),
    .first_mism_addr_o (first_mism_addr_o),
    .mem_req_o         (mem_req_o),
    .mem_we_o          (mem_we_o),
    .mem_be_o          (mem_be_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_rvalid_i      (mem_rvalid_i),
    .mem_rdata_i       (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // TCM model: fixed one-cycle response; resp_en=0 models a dead responder.
  always @(posedge clk_i) begin
    if (mem_req_o && resp_en) begin
      mem_rvalid_i <= 1'b1;
      mem_rdata_i  <= mem[mem_addr_o[11:2]];
      if (mem_we_o) mem[mem_addr_o[11:2]] = mem_wdata_o;
    end else begin
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= 32'h0;
    end
  end

  // Issues one command and runs until done_o; cycle 1 is the first cycle after accept.
  task automatic run_cmd(input logic [1:0] mode, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] len, input logic [31:0] pat, output int done_cyc);
    for (int i = 0; i < 50 && !cmd_ready_o; i++) begin
      @(posedge clk_i); #1;
    end
    cmd_mode_i = mode; cmd_src_i = src; cmd_dst_i = dst; cmd_len_i = len; cmd_pattern_i = pat;
    cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    nreq = 0; nwr = 0; we_pat = '0; done_cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      abort_i = (c == abort_at);
      if (mem_req_o) begin
        if (nreq < 8) req_cyc[nreq] = c;
        nreq++;
        we_pat = {we_pat[14:0], mem_we_o};
        if (mem_we_o) nwr++;
      end
      if (done_o) begin
        done_cyc = c;
        break;
      end
      @(posedge clk_i); #1;
    end
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    total++; if (status_o !== 2'd0) begin bad++; $display("FAIL reset_status got=%0d exp=0", status_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_req_o); end
    total++; if (mism_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_mism got=%0d exp=0", mism_cnt_o); end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_copy();
    mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC;
    for (int i = 64; i < 67; i++) mem[i] = 32'h0;
    run_cmd(2'd0, 32'h000, 32'h100, 16'd3, 32'h0, dc);
    total++; if (dc != 13) begin bad++; $display("FAIL copy_done_cycle got=%0d exp=13", dc); end
    total++; if (status_o !== 2'd0) begin bad++; $display("FAIL copy_status got=%0d exp=0", status_o); end
    total++; if (nreq != 6) begin bad++; $display("FAIL copy_nreq got=%0d exp=6", nreq); end
    total++; if (we_pat[5:0] !== 6'b010101) begin bad++; $display("FAIL copy_we_pattern got=%b exp=010101", we_pat[5:0]); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem[64+i] !== 32'hA + 32'(i)) begin bad++; $display("FAIL copy_word%0d got=%h exp=%h", i, mem[64+i], 32'hA + 32'(i)); end
    end
  endtask

  task automatic test_fill();
    run_cmd(2'd1, 32'h0, 32'h040, 16'd4, 32'hDEADBEEF, dc);
    total++; if (dc != 9) begin bad++; $display("FAIL fill_done_cycle got=%0d exp=9", dc); end
    total++; if (nreq != 4) begin bad++; $display("FAIL fill_nreq got=%0d exp=4", nreq); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (req_cyc[i] != 1 + 2*i) begin bad++; $display("FAIL fill_req%0d_cycle got=%0d exp=%0d", i, req_cyc[i], 1 + 2*i); end
      total++;
      if (mem[16+i] !== 32'hDEADBEEF) begin bad++; $display("FAIL fill_word%0d got=%h exp=deadbeef", i, mem[16+i]); end
    end
    total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL fin_ready got=%b exp=0", cmd_ready_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL fin_busy got=%b exp=1", busy_o); end
    @(posedge clk_i); #1;
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b exp=0", done_o); end
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", cmd_ready_o); end
  endtask

  task automatic test_check();
    mem[0] = 32'd5; mem[1] = 32'd7; mem[2] = 32'd5; mem[3] = 32'd9;
    run_cmd(2'd2, 32'h0, 32'h0, 16'd4, 32'd5, dc);
    total++; if (dc != 9) begin bad++; $display("FAIL check_done_cycle got=%0d exp=9", dc); end
    total++; if (mism_cnt_o !== 16'd2) begin bad++; $display("FAIL check_mism got=%0d exp=2", mism_cnt_o); end
    total++; if (first_mism_addr_o !== 32'h4) begin bad++; $display("FAIL check_first got=%h exp=4", first_mism_addr_o); end
    total++; if (status_o !== 2'd0) begin bad++; $display("FAIL check_status got=%0d exp=0", status_o); end
    total++; if (nwr != 0) begin bad++; $display("FAIL check_writes got=%0d exp=0", nwr); end
  endtask

  task automatic test_cmd_err();
    run_cmd(2'd0, 32'h2, 32'h100, 16'd1, 32'h0, dc);
    total++; if (dc != 1) begin bad++; $display("FAIL misalign_done_cycle got=%0d exp=1", dc); end
    total++; if (status_o !== 2'd1) begin bad++; $display("FAIL misalign_status got=%0d exp=1", status_o); end
    total++; if (nreq != 0) begin bad++; $display("FAIL misalign_nreq got=%0d exp=0", nreq); end
    total++; if (mism_cnt_o !== 16'd0) begin bad++; $display("FAIL accept_clears_mism got=%0d exp=0", mism_cnt_o); end
    run_cmd(2'd1, 32'h0, 32'h10, 16'd0, 32'h1, dc);
    total++; if (dc != 1) begin bad++; $display("FAIL len0_done_cycle got=%0d exp=1", dc); end
    total++; if (status_o !== 2'd0) begin bad++; $display("FAIL len0_status got=%0d exp=0", status_o); end
    total++; if (nreq != 0) begin bad++; $display("FAIL len0_nreq got=%0d exp=0", nreq); end
    run_cmd(2'd1, 32'h0, 32'hFFC, 16'd2, 32'h1, dc);
    total++; if (status_o !== 2'd1) begin bad++; $display("FAIL range_status got=%0d exp=1", status_o); end
    total++; if (nreq != 0) begin bad++; $display("FAIL range_nreq got=%0d exp=0", nreq); end
    run_cmd(2'd3, 32'h0, 32'h0, 16'd1, 32'h1, dc);
    total++; if (status_o !== 2'd1) begin bad++; $display("FAIL rsvd_status got=%0d exp=1", status_o); end
    run_cmd(2'd1, 32'h0, 32'hFFC, 16'd1, 32'h77, dc);
    total++; if (dc != 3) begin bad++; $display("FAIL top_word_done_cycle got=%0d exp=3", dc); end
    total++; if (status_o !== 2'd0) begin bad++; $display("FAIL top_word_status got=%0d exp=0", status_o); end
    total++; if (mem[1023] !== 32'h77) begin bad++; $display("FAIL top_word_data got=%h exp=77", mem[1023]); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) begin
      mem[i] = 32'h100 + 32'(i);
      mem[128+i] = 32'h0;
    end
    abort_at = 10;
    run_cmd(2'd0, 32'h000, 32'h200, 16'd8, 32'h0, dc);
    abort_at = -1;
    total++; if (dc != 13) begin bad++; $display("FAIL abort_done_cycle got=%0d exp=13", dc); end
    total++; if (status_o !== 2'd2) begin bad++; $display("FAIL abort_status got=%0d exp=2", status_o); end
    total++; if (nwr != 3) begin bad++; $display("FAIL abort_writes got=%0d exp=3", nwr); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem[128+i] !== 32'h100 + 32'(i)) begin bad++; $display("FAIL abort_word%0d got=%h exp=%h", i, mem[128+i], 32'h100 + 32'(i)); end
    end
    total++; if (mem[131] !== 32'h0) begin bad++; $display("FAIL abort_word3 got=%h exp=0", mem[131]); end
  endtask

  task automatic test_timeout();
    resp_en = 1'b0;
    run_cmd(2'd1, 32'h0, 32'h0, 16'd1, 32'h1, dc);
    resp_en = 1'b1;
    total++; if (dc != 17) begin bad++; $display("FAIL timeout_done_cycle got=%0d exp=17", dc); end
    total++; if (status_o !== 2'd3) begin bad++; $display("FAIL timeout_status got=%0d exp=3", status_o); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    for (int i = 0; i < 50 && !cmd_ready_o; i++) begin
      @(posedge clk_i); #1;
    end
    cmd_mode_i = 2'd1; cmd_src_i = 32'h0; cmd_dst_i = 32'h80; cmd_len_i = 16'd4;
    cmd_pattern_i = 32'h1234; cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", cmd_ready_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_mid_req got=%b exp=0", mem_req_o); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_o || busy_o) pulses++;
      @(posedge clk_i); #1;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d exp=0", pulses); end
    run_cmd(2'd1, 32'h0, 32'h80, 16'd1, 32'h55, dc);
    total++; if (dc != 3) begin bad++; $display("FAIL rst_recover_done_cycle got=%0d exp=3", dc); end
    total++; if (mem[32] !== 32'h55) begin bad++; $display("FAIL rst_recover_data got=%h exp=55", mem[32]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_copy();
    test_fill();
    test_check();
    test_cmd_err();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
